// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, step encodings and
// control-word bit positions. Optional build macro: CTRL_COND_JUMP_EN.
package ctrl_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_EXEC0  = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam int CW_W          = 15;
  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_IN     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OUT      = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_OUT    = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_FLAGS_LOAD = 13;
  localparam int CW_OUT_LOAD   = 14;

  typedef logic [CW_W-1:0] ctrl_word_t;

  function automatic ctrl_word_t cw_bit(input int idx);
    cw_bit = ctrl_word_t'(15'd1) << idx;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational microcode: (step, opcode, flags) -> control word and next step.
// Conditional jumps JC/JZ exist only when CTRL_COND_JUMP_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter logic [OPC_W-1:0] HLT_OP = OP_HLT
) (
  input  state_t           state,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output ctrl_word_t       cw,
  output state_t           next_state
);

  ctrl_word_t fetch_addr;
  ctrl_word_t jump_w;

  assign fetch_addr = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
  assign jump_w     = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);

`ifndef CTRL_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
`endif

  always_comb begin
    cw         = '0;
    next_state = ST_FETCH0;
    case (state)
      ST_FETCH0: begin
        cw         = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
        next_state = ST_FETCH1;
      end
      ST_FETCH1: begin
        cw         = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
        next_state = ST_EXEC0;
      end
      ST_EXEC0: begin
        // Halt is checked first so a re-parameterised HLT_OP may alias any opcode.
        if (opcode == HLT_OP) begin
          next_state = ST_HALT;
        end else begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw         = fetch_addr;
              next_state = ST_EXEC1;
            end
            OP_LDI:  cw = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
            OP_JMP:  cw = jump_w;
`ifdef CTRL_COND_JUMP_EN
            OP_JC:   cw = flag_c ? jump_w : '0;
            OP_JZ:   cw = flag_z ? jump_w : '0;
`endif
            OP_OUT:  cw = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
            default: cw = '0;
          endcase
        end
      end
      ST_EXEC1: begin
        case (opcode)
          OP_LDA: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
          OP_ADD, OP_SUB: begin
            cw         = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
            next_state = ST_EXEC2;
          end
          OP_STA:  cw = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
          default: cw = '0;
        endcase
      end
      ST_EXEC2: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD);
          cw[CW_ALU_SUB] = (opcode == OP_SUB);
        end else begin
          cw = '0;
        end
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_FETCH0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: step register, run/reset gating of strobes.
// Build with CTRL_COND_JUMP_EN defined to enable the JC/JZ conditional jumps.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int               OPCODE_W = 4,
  parameter logic [OPC_W-1:0] HLT_OP   = OP_HLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic                pc_out,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_out,
  output logic                ram_in,
  output logic                ir_load,
  output logic                ir_out,
  output logic                a_load,
  output logic                a_out,
  output logic                b_load,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_load,
  output logic                halted,
  output logic [2:0]          step
);

  state_t     state_q, state_d, dec_next;
  ctrl_word_t dec_cw, cw_gated;
  logic       enable;

  ctrl_decode #(.HLT_OP(HLT_OP)) u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .cw         (dec_cw),
    .next_state (dec_next)
  );

  assign enable = run & ~reset;

  // A stalled step is held, so resuming re-enters the same step exactly once.
  always_comb begin
    state_d  = run ? dec_next : state_q;
    cw_gated = enable ? dec_cw : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH0;
    else       state_q <= state_d;
  end

  assign pc_out     = cw_gated[CW_PC_OUT];
  assign pc_inc     = cw_gated[CW_PC_INC];
  assign pc_load    = cw_gated[CW_PC_LOAD];
  assign mar_load   = cw_gated[CW_MAR_LOAD];
  assign ram_out    = cw_gated[CW_RAM_OUT];
  assign ram_in     = cw_gated[CW_RAM_IN];
  assign ir_load    = cw_gated[CW_IR_LOAD];
  assign ir_out     = cw_gated[CW_IR_OUT];
  assign a_load     = cw_gated[CW_A_LOAD];
  assign a_out      = cw_gated[CW_A_OUT];
  assign b_load     = cw_gated[CW_B_LOAD];
  assign alu_out    = cw_gated[CW_ALU_OUT];
  assign alu_sub    = cw_gated[CW_ALU_SUB];
  assign flags_load = cw_gated[CW_FLAGS_LOAD];
  assign out_load   = cw_gated[CW_OUT_LOAD];
  assign halted     = ~reset & (state_q == ST_HALT);
  assign step       = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, hand-written
// stall/halt/reset sequences and a randomized run against an instruction-level model.
module tb_control_sequencer;

  logic       clk, reset, run, flag_c, flag_z;
  logic [3:0] opcode;
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
  logic [2:0] step;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_out(ram_out), .ram_in(ram_in), .ir_load(ir_load), .ir_out(ir_out),
    .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
    .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
    .halted(halted), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [14:0] M_PC_OUT = 15'h0001, M_PC_INC = 15'h0002, M_PC_LOAD = 15'h0004;
  localparam logic [14:0] M_MAR = 15'h0008, M_RAM_OUT = 15'h0010, M_RAM_IN = 15'h0020;
  localparam logic [14:0] M_IR_LOAD = 15'h0040, M_IR_OUT = 15'h0080, M_A_LOAD = 15'h0100;
  localparam logic [14:0] M_A_OUT = 15'h0200, M_B_LOAD = 15'h0400, M_ALU_OUT = 15'h0800;
  localparam logic [14:0] M_ALU_SUB = 15'h1000, M_FLAGS = 15'h2000, M_OUT_LOAD = 15'h4000;
  localparam logic [14:0] BUS_MASK = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;
  localparam logic [14:0] F0 = M_PC_OUT | M_MAR;
  localparam logic [14:0] F1 = M_RAM_OUT | M_IR_LOAD | M_PC_INC;
  localparam logic [14:0] ADR = M_IR_OUT | M_MAR;
  localparam logic [14:0] JMPW = M_IR_OUT | M_PC_LOAD;
`ifdef CTRL_COND_JUMP_EN
  localparam logic [14:0] W_CJ = JMPW;
`else
  localparam logic [14:0] W_CJ = 15'h0000;
`endif

  logic [14:0] act_w;
  assign act_w = {out_load, flags_load, alu_sub, alu_out, b_load, a_out, a_load, ir_out,
                  ir_load, ram_in, ram_out, mar_load, pc_load, pc_inc, pc_out};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [2:0] es, input logic eh, input logic [14:0] ew);
    n_vec++;
    if (step !== es || halted !== eh || act_w !== ew || $countones(act_w & BUS_MASK) > 1) begin
      n_bad++;
      $display("FAIL %s: got step=%0d halted=%0b strobes=%h, want step=%0d halted=%0b strobes=%h",
               name, step, halted, act_w, es, eh, ew);
    end
  endtask

  task automatic drive(input logic r, input logic ru, input logic [3:0] o, input logic c, input logic z);
    @(negedge clk);
    reset = r; run = ru; opcode = o; flag_c = c; flag_z = z;
    #1;
  endtask

  typedef struct {
    logic r; logic ru; logic [3:0] op; logic c; logic z;
    logic [2:0] es; logic eh; logic [14:0] ew; string name;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic ru, input logic [3:0] op, input logic c, input logic z,
                     input logic [2:0] es, input logic eh, input logic [14:0] ew, input string name);
    vec_t v;
    v.r = r; v.ru = ru; v.op = op; v.c = c; v.z = z; v.es = es; v.eh = eh; v.ew = ew; v.name = name;
    tbl.push_back(v);
  endtask

  // Instruction-level reference: cycle count and strobes per micro-step k.
  function automatic int inst_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] micro(input logic [3:0] op, input int k, input logic c, input logic z);
    if (k == 0) return F0;
    if (k == 1) return F1;
    case (op)
      4'h1: return (k == 2) ? ADR : (M_RAM_OUT | M_A_LOAD);
      4'h2, 4'h3: begin
        if (k == 2) return ADR;
        if (k == 3) return M_RAM_OUT | M_B_LOAD;
        return M_ALU_OUT | M_A_LOAD | M_FLAGS | ((op == 4'h3) ? M_ALU_SUB : 15'h0000);
      end
      4'h4: return (k == 2) ? ADR : (M_A_OUT | M_RAM_IN);
      4'h5: return M_IR_OUT | M_A_LOAD;
      4'h6: return JMPW;
`ifdef CTRL_COND_JUMP_EN
      4'h7: return c ? JMPW : 15'h0000;
      4'h8: return z ? JMPW : 15'h0000;
`endif
      4'hE: return M_A_OUT | M_OUT_LOAD;
      default: return 15'h0000;
    endcase
  endfunction

  int          mk, halt_cnt;
  logic        mh;
  logic [2:0]  es;
  logic [14:0] ew;

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    repeat (2) @(posedge clk);

    add(1, 1, 4'h0, 0, 0, 3'd0, 0, 15'h0000, "reset");
    add(0, 1, 4'h0, 0, 0, 3'd0, 0, F0, "nop_f0");
    add(0, 1, 4'h0, 0, 0, 3'd1, 0, F1, "nop_f1");
    add(0, 1, 4'h0, 0, 0, 3'd2, 0, 15'h0000, "nop_e0");
    add(0, 1, 4'h2, 0, 0, 3'd0, 0, F0, "add_f0");
    add(0, 1, 4'h2, 0, 0, 3'd1, 0, F1, "add_f1");
    add(0, 1, 4'h2, 0, 0, 3'd2, 0, ADR, "add_e0");
    add(0, 1, 4'h2, 0, 0, 3'd3, 0, M_RAM_OUT | M_B_LOAD, "add_e1");
    add(0, 1, 4'h2, 0, 0, 3'd4, 0, M_ALU_OUT | M_A_LOAD | M_FLAGS, "add_e2");
    add(0, 1, 4'h3, 0, 0, 3'd0, 0, F0, "sub_f0");
    add(0, 1, 4'h3, 0, 0, 3'd1, 0, F1, "sub_f1");
    add(0, 1, 4'h3, 0, 0, 3'd2, 0, ADR, "sub_e0");
    add(0, 1, 4'h3, 0, 0, 3'd3, 0, M_RAM_OUT | M_B_LOAD, "sub_e1");
    add(0, 1, 4'h3, 0, 0, 3'd4, 0, M_ALU_OUT | M_A_LOAD | M_FLAGS | M_ALU_SUB, "sub_e2");
    add(0, 1, 4'h7, 1, 0, 3'd0, 0, F0, "jc1_f0");
    add(0, 1, 4'h7, 1, 0, 3'd1, 0, F1, "jc1_f1");
    add(0, 1, 4'h7, 1, 0, 3'd2, 0, W_CJ, "jc1_e0");
    add(0, 1, 4'h7, 0, 1, 3'd0, 0, F0, "jc0_f0");
    add(0, 1, 4'h7, 0, 1, 3'd1, 0, F1, "jc0_f1");
    add(0, 1, 4'h7, 0, 1, 3'd2, 0, 15'h0000, "jc0_e0");
    add(0, 1, 4'h8, 0, 1, 3'd0, 0, F0, "jz1_f0");
    add(0, 1, 4'h8, 0, 1, 3'd1, 0, F1, "jz1_f1");
    add(0, 1, 4'h8, 0, 1, 3'd2, 0, W_CJ, "jz1_e0");
    add(0, 1, 4'h5, 0, 0, 3'd0, 0, F0, "ldi_f0");
    add(0, 1, 4'h5, 0, 0, 3'd1, 0, F1, "ldi_f1");
    add(0, 1, 4'h5, 0, 0, 3'd2, 0, M_IR_OUT | M_A_LOAD, "ldi_e0");
    add(0, 1, 4'h6, 0, 0, 3'd0, 0, F0, "jmp_f0");
    add(0, 1, 4'h6, 0, 0, 3'd1, 0, F1, "jmp_f1");
    add(0, 1, 4'h6, 0, 0, 3'd2, 0, JMPW, "jmp_e0");
    add(0, 1, 4'hE, 0, 0, 3'd0, 0, F0, "out_f0");
    add(0, 1, 4'hE, 0, 0, 3'd1, 0, F1, "out_f1");
    add(0, 1, 4'hE, 0, 0, 3'd2, 0, M_A_OUT | M_OUT_LOAD, "out_e0");

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].ru, tbl[i].op, tbl[i].c, tbl[i].z);
      check(tbl[i].name, tbl[i].es, tbl[i].eh, tbl[i].ew);
    end

    // Halt: reached after three cycles, sticky, cleared only by reset.
    drive(0, 1, 4'hF, 0, 0); check("hlt_f0", 3'd0, 0, F0);
    drive(0, 1, 4'hF, 0, 0); check("hlt_f1", 3'd1, 0, F1);
    drive(0, 1, 4'hF, 0, 0); check("hlt_e0", 3'd2, 0, 15'h0000);
    for (int i = 0; i < 20; i++) begin
      drive(0, (i % 3) != 0, 4'hF, 1, 1); check("halt_hold", 3'd5, 1, 15'h0000);
    end
    drive(1, 1, 4'h1, 0, 0); check("halt_reset", 3'd5, 0, 15'h0000);
    drive(0, 1, 4'h1, 0, 0); check("post_halt_f0", 3'd0, 0, F0);

    // LDA stalled in EXEC1: load fires once on resume.
    drive(0, 1, 4'h1, 0, 0); check("lda_f1", 3'd1, 0, F1);
    drive(0, 1, 4'h1, 0, 0); check("lda_e0", 3'd2, 0, ADR);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'h1, 0, 0); check("lda_stall", 3'd3, 0, 15'h0000);
    end
    drive(0, 1, 4'h1, 0, 0); check("lda_e1", 3'd3, 0, M_RAM_OUT | M_A_LOAD);

    // Reset during STA EXEC1 suppresses the RAM write.
    drive(0, 1, 4'h4, 0, 0); check("sta_f0", 3'd0, 0, F0);
    drive(0, 1, 4'h4, 0, 0); check("sta_f1", 3'd1, 0, F1);
    drive(0, 1, 4'h4, 0, 0); check("sta_e0", 3'd2, 0, ADR);
    drive(1, 1, 4'h4, 0, 0); check("sta_reset", 3'd3, 0, 15'h0000);
    drive(0, 1, 4'h4, 0, 0); check("sta_after", 3'd0, 0, F0);

    drive(1, 0, 4'h0, 0, 0);
    @(posedge clk);
    mk = 0; mh = 1'b0; halt_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) < 3) || (halt_cnt > 6);
      run   = ($urandom_range(0, 3) != 0);
      if (!mh && mk <= 1) begin
        opcode = 4'($urandom_range(0, 15));
        if (opcode == 4'hF && $urandom_range(0, 3) != 0) opcode = 4'h0;
      end
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      #1;
      es = mh ? 3'd5 : 3'(mk);
      ew = (reset || !run || mh) ? 15'h0000 : micro(opcode, mk, flag_c, flag_z);
      check("random", es, mh & ~reset, ew);
      @(posedge clk);
      if (reset) begin
        mk = 0; mh = 1'b0;
      end else if (run && !mh) begin
        if (mk == inst_len(opcode) - 1) begin
          if (opcode == 4'hF) mh = 1'b1;
          else mk = 0;
        end else begin
          mk++;
        end
      end
      halt_cnt = mh ? halt_cnt + 1 : 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
